// File: rtl/pkt_tx.sv
// -----------------------------------------------------------------------------
// pkt_tx -- packet transmitter feeding a router input port.
//
// Payload bytes are queued in a 64-byte FIFO. A request (start/addr/len) taken
// in IDLE emits a header byte {len, addr}, then len payload bytes popped from
// the FIFO, then an even-parity byte (XOR of header and payload). GAP_CYCLES
// idle cycles follow before the next request is considered. busy from the
// router freezes the byte currently on dout.
//
// Optional feature: define PKT_TX_PARITY_ERR_EN to let corrupt (sampled at
// accept) invert that packet's parity byte. Without it corrupt is ignored.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   wr_en, wr_data     payload byte write (dropped while wr_full)
//   wr_full, fill      FIFO full flag and occupancy (0-64)
//   start, addr, len   packet request, sampled in IDLE
//   accept, addr_err   one-cycle request taken / rejected (addr=3) pulses
//   busy               router back-pressure
//   dout, pkt_vd       registered byte and valid (valid low on parity byte)
//   done               one-cycle pulse after the parity byte is consumed
//   corrupt            parity inversion request
// -----------------------------------------------------------------------------
module pkt_tx #(
    parameter int FIFO_DEPTH = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_full,
    output logic [6:0] fill,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
    output logic       accept,
    output logic       addr_err,
    input  logic       busy,
    output logic [7:0] dout,
    output logic       pkt_vd,
    output logic       done,
    input  logic       corrupt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr_q, rd_ptr_q;
    logic [6:0] count_q;
    logic       wr_ok, pop;

    logic [2:0] state_q, state_d;
    logic [7:0] dout_q, dout_d;
    logic       pkt_vd_q, pkt_vd_d;
    logic       accept_q, accept_d;
    logic       addr_err_q, addr_err_d;
    logic       done_q, done_d;
    logic [5:0] cnt_q, cnt_d;      // payload bytes left after current one, or gap cycles left
    logic [7:0] par_q, par_d;      // running XOR of every byte loaded onto dout
    logic [5:0] len_q, len_d;
    logic [1:0] addr_q, addr_d;
    logic       inv_q, inv_d;

    logic [7:0] head_byte, cur_byte, next_byte, par_out;

    assign wr_full   = (count_q == 7'(FIFO_DEPTH));
    assign fill      = count_q;
    // Full is judged on the pre-pop occupancy, so a write at full is dropped
    // even if a byte leaves on the same edge.
    assign wr_ok     = wr_en && !wr_full;

    assign head_byte = {len_q, addr_q};
    assign cur_byte  = mem[rd_ptr_q];
    assign next_byte = mem[rd_ptr_q + 6'd1];
    assign par_out   = par_q ^ {8{inv_q}};

    assign dout      = dout_q;
    assign pkt_vd    = pkt_vd_q;
    assign accept    = accept_q;
    assign addr_err  = addr_err_q;
    assign done      = done_q;

`ifdef PKT_TX_PARITY_ERR_EN
`else
    logic unused_corrupt;
    assign unused_corrupt = corrupt;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        pkt_vd_d   = pkt_vd_q;
        accept_d   = 1'b0;
        addr_err_d = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        par_d      = par_q;
        len_d      = len_q;
        addr_d     = addr_q;
        inv_d      = inv_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                dout_d   = 8'h00;
                pkt_vd_d = 1'b0;
                if (start) begin
                    if (addr == 2'd3) begin
                        addr_err_d = 1'b1;
                    end else if (count_q >= {1'b0, len}) begin
                        accept_d = 1'b1;
                        len_d    = len;
                        addr_d   = addr;
`ifdef PKT_TX_PARITY_ERR_EN
                        inv_d    = corrupt;
`else
                        inv_d    = 1'b0;
`endif
                        state_d  = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                // The accept cycle is spent in HEADER with nothing on dout yet;
                // the header byte is loaded on the following edge.
                if (!pkt_vd_q) begin
                    dout_d   = head_byte;
                    pkt_vd_d = 1'b1;
                    par_d    = head_byte;
                end else if (!busy) begin
                    if (len_q == 6'd0) begin
                        state_d  = S_PARITY;
                        dout_d   = par_out;
                        pkt_vd_d = 1'b0;
                    end else begin
                        state_d = S_PAYLOAD;
                        dout_d  = cur_byte;
                        par_d   = par_q ^ cur_byte;
                        cnt_d   = len_q - 6'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                // The byte on dout is popped only when the router takes it.
                if (!busy) begin
                    pop = 1'b1;
                    if (cnt_q == 6'd0) begin
                        state_d  = S_PARITY;
                        dout_d   = par_out;
                        pkt_vd_d = 1'b0;
                    end else begin
                        dout_d = next_byte;
                        par_d  = par_q ^ next_byte;
                        cnt_d  = cnt_q - 6'd1;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    state_d = S_GAP;
                    dout_d  = 8'h00;
                    cnt_d   = 6'(GAP_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (cnt_q == 6'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 6'd1;
            end
            default: begin
                state_d  = S_IDLE;
                dout_d   = 8'h00;
                pkt_vd_d = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            dout_q     <= 8'h00;
            pkt_vd_q   <= 1'b0;
            accept_q   <= 1'b0;
            addr_err_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= 6'd0;
            par_q      <= 8'h00;
            len_q      <= 6'd0;
            addr_q     <= 2'd0;
            inv_q      <= 1'b0;
            wr_ptr_q   <= 6'd0;
            rd_ptr_q   <= 6'd0;
            count_q    <= 7'd0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            pkt_vd_q   <= pkt_vd_d;
            accept_q   <= accept_d;
            addr_err_q <= addr_err_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            inv_q      <= inv_d;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 6'd1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 6'd1;
            case ({wr_ok, pop})
                2'b10:   count_q <= count_q + 7'd1;
                2'b01:   count_q <= count_q - 7'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; resetting the pointers and count
    // empties the FIFO, and stale contents are never read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_pkt_tx -- self-checking bench for pkt_tx.
//
// A queue models the payload FIFO; each packet's expected byte stream is
// built from the queue contents at accept time (header, payload, XOR parity).
// Back-pressure and concurrent writes are randomized with $urandom. Outputs
// are sampled 1 time unit after each rising edge, where inputs are also
// updated for the next edge.
// -----------------------------------------------------------------------------
module tb_pkt_tx;

    localparam int GAP = 2;

    logic       clk, rstn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;
    logic [6:0] fill;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       accept, addr_err, busy;
    logic [7:0] dout;
    logic       pkt_vd, done, corrupt;

    pkt_tx #(.FIFO_DEPTH(64), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .fill(fill),
        .start(start), .addr(addr), .len(len),
        .accept(accept), .addr_err(addr_err), .busy(busy),
        .dout(dout), .pkt_vd(pkt_vd), .done(done), .corrupt(corrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge; the model FIFO takes the write (judged on pre-edge
    // occupancy) and the pop requested by the caller.
    task automatic tick(input bit pop_byte);
        bit         do_wr;
        logic [7:0] d;
        do_wr = wr_en && (model_q.size() < 64);
        d     = wr_data;
        @(posedge clk);
        #1;
        if (do_wr)    model_q.push_back(d);
        if (pop_byte) void'(model_q.pop_front());
    endtask

    task automatic rand_write(input int pct);
        wr_en   = ($urandom_range(0, 99) < pct);
        wr_data = 8'($urandom);
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_fill"}, fill, model_q.size());
        check({tag, "_wr_full"}, wr_full, model_q.size() == 64);
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; wr_en = 1'b0; busy = 1'b0; corrupt = 1'b0;
        #2;
        model_q.delete();
        check("rst_dout", dout, 8'h00);
        check("rst_pkt_vd", pkt_vd, 1'b0);
        check("rst_accept", accept, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_done", done, 1'b0);
        check_fifo("rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic fill_to(input int n);
        int guard;
        guard = 0;
        start = 1'b0;
        wr_en = 1'b1;
        while (model_q.size() < n && guard < 100) begin
            wr_data = 8'($urandom);
            tick(1'b0);
            guard++;
        end
        wr_en = 1'b0;
        check("fill_to", fill, model_q.size());
    endtask

    // Full packet: request, stream with random back-pressure and writes,
    // done pulse, then the gap measured by an addr=3 probe.
    task automatic run_packet(input logic [1:0] a, input logic [5:0] l,
                              input int busy_pct, input int wr_pct, input bit corr);
        logic [7:0] exp_bytes[$];
        logic [7:0] par;
        bit         inv, consumed;
        int         idx, budget, last;

        start = 1'b1; addr = a; len = l; corrupt = corr;
        busy = 1'($urandom_range(0, 1));
        rand_write(wr_pct);
        tick(1'b0);
        check("accept", accept, 1'b1);
        check("addr_err_on_accept", addr_err, 1'b0);
        start = 1'b0;
        corrupt = 1'($urandom_range(0, 1));

        exp_bytes.push_back({l, a});
        for (int i = 0; i < int'(l); i++) exp_bytes.push_back(model_q[i]);
        par = 8'h00;
        foreach (exp_bytes[i]) par ^= exp_bytes[i];
`ifdef PKT_TX_PARITY_ERR_EN
        inv = corr;
`else
        inv = 1'b0;
`endif
        exp_bytes.push_back(inv ? ~par : par);
        last = exp_bytes.size() - 1;

        rand_write(wr_pct);
        tick(1'b0);
        check("accept_pulse", accept, 1'b0);
        idx = 0;
        budget = 0;
        while (idx <= last && budget < 2000) begin
            check("dout", dout, exp_bytes[idx]);
            check("pkt_vd", pkt_vd, idx != last);
            check("done_early", done, 1'b0);
            check_fifo("stream");
            busy = ($urandom_range(0, 99) < busy_pct);
            rand_write(wr_pct);
            consumed = !busy;
            tick(consumed && idx >= 1 && idx <= int'(l));
            if (consumed) idx++;
            budget++;
        end
        check("stream_complete", idx, last + 1);

        check("done", done, 1'b1);
        check("gap_dout", dout, 8'h00);
        check("gap_pkt_vd", pkt_vd, 1'b0);
        start = 1'b1; addr = 2'd3;
        for (int k = 1; k <= GAP + 1; k++) begin
            rand_write(wr_pct);
            tick(1'b0);
            check("gap_addr_err", addr_err, k == GAP + 1);
            check("gap_accept", accept, 1'b0);
            check("gap_done", done, 1'b0);
            check("gap_pkt_vd", pkt_vd, 1'b0);
        end
        start = 1'b0; wr_en = 1'b0;
        tick(1'b0);
        check("addr_err_pulse", addr_err, 1'b0);
        check_fifo("post");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq3[3];
        logic [5:0] l;
        int         guard;
        seq3[0] = 8'h11; seq3[1] = 8'h22; seq3[2] = 8'h33;
        wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; addr = 2'd0; len = 6'd0;
        busy = 1'b0; corrupt = 1'b0; rstn = 1'b1;
        #3;
        do_reset();

        // Basic three-byte packet, then the same with back-pressure and corrupt.
        for (int pass = 0; pass < 3; pass++) begin
            wr_en = 1'b1;
            for (int i = 0; i < 3; i++) begin
                wr_data = seq3[i];
                tick(1'b0);
            end
            wr_en = 1'b0;
            run_packet(2'd1, 6'd3, pass == 0 ? 0 : 50, 0, pass == 2);
        end

        // Zero-length packet.
        run_packet(2'd2, 6'd0, 30, 0, 1'b0);

        // Request waits until enough payload is buffered.
        do_reset();
        fill_to(2);
        start = 1'b1; addr = 2'd0; len = 6'd5;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            check("short_no_accept", accept, 1'b0);
            check("short_no_err", addr_err, 1'b0);
        end
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'($urandom);
            tick(1'b0);
            check("wait_no_accept", accept, 1'b0);
        end
        wr_en = 1'b0;
        check("fill_reached", fill, 7'd5);
        tick(1'b0);
        check("late_accept", accept, 1'b1);
        start = 1'b0;
        do_reset();

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            l = 6'($urandom_range(0, 63));
            fill_to(int'(l) + int'($urandom_range(0, 3)));
            run_packet(2'($urandom_range(0, 2)), l, int'($urandom_range(0, 60)),
                       int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
        end

        // Overfill: the 65th byte is dropped, then drain across the pointer wrap.
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 65; i++) begin
            wr_data = 8'(i + 1);
            tick(1'b0);
        end
        wr_en = 1'b0;
        check("full_fill", fill, 7'd64);
        check("full_flag", wr_full, 1'b1);
        run_packet(2'd0, 6'd63, 20, 0, 1'b0);
        check("drain_fill", fill, 7'd1);
        run_packet(2'd1, 6'd1, 20, 40, 1'b0);

        // Reset in the middle of a payload abandons the packet.
        fill_to(10);
        start = 1'b1; addr = 2'd0; len = 6'd8; busy = 1'b0;
        tick(1'b0);
        check("mid_accept", accept, 1'b1);
        start = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        check("mid_payload_vd", pkt_vd, 1'b1);
        rstn = 1'b0;
        #1;
        model_q.delete();
        check("mid_rst_pkt_vd", pkt_vd, 1'b0);
        check("mid_rst_dout", dout, 8'h00);
        check_fifo("mid_rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        guard = 0;
        while (guard < 20) begin
            tick(1'b0);
            check("abandon_done", done, 1'b0);
            check("abandon_pkt_vd", pkt_vd, 1'b0);
            guard++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
